// File: rtl/seq_divider_16bit.sv
// Iterative unsigned restoring divider: one shift-and-subtract step per clock,
// start/done handshake, divide-by-zero reported as q=all ones, r=a.
module seq_divider_16bit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   shifted_d;
  logic             fits_d;
  logic [WIDTH-1:0] sub_d;

  // The partial remainder after a successful subtract is below the divisor,
  // so the low WIDTH bits of the difference are the whole new remainder.
  always_comb begin
    shifted_d = {rem_q, dvd_q[WIDTH-1]};
    fits_d    = shifted_d >= {1'b0, dsr_q};
    sub_d     = shifted_d[WIDTH-1:0] - dsr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      q           <= '0;
      r           <= '0;
      div_by_zero <= 1'b0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      cnt_q       <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            dvd_q   <= a;
            dsr_q   <= b;
            rem_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= (b == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          // Dividend bits leave from the MSB while quotient bits enter at the LSB.
          if (fits_d) begin
            rem_q <= sub_d;
            dvd_q <= {dvd_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_q <= shifted_d[WIDTH-1:0];
            dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
          end
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_STEP) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= IDLE;
          if (dsr_q == '0) begin
            q           <= '1;
            r           <= dvd_q;
            div_by_zero <= 1'b1;
          end else begin
            q           <= dvd_q;
            r           <= rem_q;
            div_by_zero <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
